fetch_unit: RTL and testbench

Program-counter and fetch sequencer for the 9-bit Lambo core. Holds the PC that addresses the asynchronous instruction ROM, and computes the next PC each cycle from the decoder's BranchEn / ConditionBranch / Halt / RegSet outputs and the ALU compare flag. Runs the multi-word register-load sequence: while payload words stream past it drives IsLoadingReg, which suppresses every side effect in the decoder.

---
 rtl/fetch_unit_pkg.sv | 40 ++++
 rtl/fetch_unit_branch_lut.sv | 28 ++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the Lambo fetch sequencer:
//   - fetch_state_t : sequencer state encoding
//   - LUT_W         : width of the stored branch targets
//   - BRANCH_LUT    : 16-entry branch target table, entry 0 unused
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_LOADREG = 2'd2,
        ST_HALTED  = 2'd3
    } fetch_state_t;

    localparam int unsigned LUT_W = 10;

    // Branch targets for the current program set. Entry 0 is never selected
    // by a real branch; the lookup substitutes PC+1 for it.
    localparam logic [LUT_W-1:0] BRANCH_LUT [16] = '{
        10'h000, // 0: unused
        10'h080, // 1
        10'h100, // 2
        10'h120, // 3
        10'h200, // 4
        10'h00F, // 5
        10'h054, // 6
        10'h3FF, // 7
        10'h1F3, // 8
        10'h030, // 9
        10'h060, // 10
        10'h090, // 11
        10'h0C0, // 12
        10'h0F0, // 13
        10'h150, // 14
        10'h180  // 15
    };

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_branch_lut.sv
// -----------------------------------------------------------------------------
// branch_lut
// Combinational branch target lookup, kept apart so the table can be
// regenerated per program set without touching the sequencer.
// Ports:
//   idx_i      : branch LUT index (Instruction[3:0])
//   pc_plus1_i : PC+1, returned for the unused entry 0
//   target_o   : next-PC target
// -----------------------------------------------------------------------------
module branch_lut
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W = 10
) (
    input  logic [3:0]      idx_i,
    input  logic [PC_W-1:0] pc_plus1_i,
    output logic [PC_W-1:0] target_o
);

    always_comb begin
        if (idx_i == 4'd0) begin
            target_o = pc_plus1_i;
        end else begin
            target_o = PC_W'(BRANCH_LUT[idx_i]);
        end
    end

endmodule : branch_lut

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Program counter and fetch sequencer for the 9-bit Lambo core.
// Ports:
//   Clk, ResetN      : clock, asynchronous active-low reset
//   Start, StartAddr : begin execution at StartAddr (IDLE/HALTED only)
//   BranchEn, ConditionBranch, BranchIdx, CmpFlag : branch control
//   Halt, RegSet     : decoder halt / register-load instruction
//   PC               : instruction ROM address
//   IsLoadingReg     : current word is register-load payload
//   Running          : RUN or LOADREG
//   Done             : program halted, held until next Start
//   DbgState         : current sequencer state
//
// Start is a single-cycle pulse with no ready/ack: it is acted on only when
// sampled in IDLE or HALTED and silently dropped in RUN/LOADREG.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned LOAD_WORDS = 1
) (
    input  logic            Clk,
    input  logic            ResetN,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            BranchEn,
    input  logic            ConditionBranch,
    input  logic [3:0]      BranchIdx,
    input  logic            CmpFlag,
    input  logic            Halt,
    input  logic            RegSet,
    output logic [PC_W-1:0] PC,
    output logic            IsLoadingReg,
    output logic            Running,
    output logic            Done,
    output fetch_state_t    DbgState
);

    localparam int unsigned CNT_W = $clog2(LOAD_WORDS + 1);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [PC_W-1:0]  pc_plus1;
    logic [PC_W-1:0]  lut_target;
    logic             taken;

    // Wraps modulo 2^PC_W by truncation.
    assign pc_plus1 = pc_q + PC_W'(1);
    assign taken    = BranchEn & (~ConditionBranch | CmpFlag);

    branch_lut #(
        .PC_W (PC_W)
    ) u_branch_lut (
        .idx_i      (BranchIdx),
        .pc_plus1_i (pc_plus1),
        .target_o   (lut_target)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = done_q;

        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (Start) begin
                    pc_d    = StartAddr;
                    done_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Halt outranks a branch even though the decoder never
                // raises both.
                if (Halt) begin
                    done_d  = 1'b1;
                    state_d = ST_HALTED;
                end else if (taken) begin
                    pc_d = lut_target;
                end else if (RegSet) begin
                    pc_d    = pc_plus1;
                    cnt_d   = CNT_W'(LOAD_WORDS);
                    state_d = ST_LOADREG;
                end else begin
                    pc_d = pc_plus1;
                end
            end

            ST_LOADREG: begin
                // Decoder inputs are already gated by IsLoadingReg here.
                pc_d  = pc_plus1;
                cnt_d = cnt_q - CNT_W'(1);
                // A zero count is unreachable; treat it as the last word.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs from the state register only: no path from the decoder
    // back into IsLoadingReg.
    assign PC           = pc_q;
    assign IsLoadingReg = (state_q == ST_LOADREG);
    assign Running      = (state_q == ST_RUN) || (state_q == ST_LOADREG);
    assign Done         = done_q;
    assign DbgState     = state_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned PC_W       = 10;
    localparam int unsigned LOAD_WORDS = 2;

    logic            Clk;
    logic            ResetN;
    logic            Start;
    logic [PC_W-1:0] StartAddr;
    logic            BranchEn;
    logic            ConditionBranch;
    logic [3:0]      BranchIdx;
    logic            CmpFlag;
    logic            Halt;
    logic            RegSet;
    logic [PC_W-1:0] PC;
    logic            IsLoadingReg;
    logic            Running;
    logic            Done;
    fetch_state_t    DbgState;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .PC_W       (PC_W),
        .LOAD_WORDS (LOAD_WORDS)
    ) dut (
        .Clk             (Clk),
        .ResetN          (ResetN),
        .Start           (Start),
        .StartAddr       (StartAddr),
        .BranchEn        (BranchEn),
        .ConditionBranch (ConditionBranch),
        .BranchIdx       (BranchIdx),
        .CmpFlag         (CmpFlag),
        .Halt            (Halt),
        .RegSet          (RegSet),
        .PC              (PC),
        .IsLoadingReg    (IsLoadingReg),
        .Running         (Running),
        .Done            (Done),
        .DbgState        (DbgState)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- vector table ----------------
    typedef struct {
        string           name;
        logic            start;
        logic [PC_W-1:0] saddr;
        logic            br;
        logic            cond;
        logic [3:0]      idx;
        logic            cmp;
        logic            halt;
        logic            rs;
        logic [PC_W-1:0] exp_pc;
        logic            exp_ld;
        logic            exp_run;
        logic            exp_done;
        fetch_state_t    exp_st;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];

    function automatic vec_t mk(string name, logic start, logic [PC_W-1:0] saddr,
                                logic br, logic cond, logic [3:0] idx, logic cmp,
                                logic halt, logic rs, logic [PC_W-1:0] exp_pc,
                                logic exp_ld, logic exp_run, logic exp_done,
                                fetch_state_t exp_st);
        vec_t v;
        v.name = name; v.start = start; v.saddr = saddr; v.br = br; v.cond = cond;
        v.idx = idx; v.cmp = cmp; v.halt = halt; v.rs = rs; v.exp_pc = exp_pc;
        v.exp_ld = exp_ld; v.exp_run = exp_run; v.exp_done = exp_done; v.exp_st = exp_st;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        Start = 1'b0; StartAddr = '0; BranchEn = 1'b0; ConditionBranch = 1'b0;
        BranchIdx = 4'd0; CmpFlag = 1'b0; Halt = 1'b0; RegSet = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        Start = v.start; StartAddr = v.saddr; BranchEn = v.br; ConditionBranch = v.cond;
        BranchIdx = v.idx; CmpFlag = v.cmp; Halt = v.halt; RegSet = v.rs;
    endtask

    // Advance one active edge, then settle away from it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [PC_W-1:0] e_pc, input logic e_ld,
                           input logic e_run, input logic e_done, input fetch_state_t e_st);
        chk({name, ".pc"},    32'(PC),           32'(e_pc));
        chk({name, ".ld"},    32'(IsLoadingReg), 32'(e_ld));
        chk({name, ".run"},   32'(Running),      32'(e_run));
        chk({name, ".done"},  32'(Done),         32'(e_done));
        chk({name, ".state"}, 32'(DbgState),     32'(e_st));
    endtask

    task automatic run_table(input vec_t tbl[$]);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            chk_all(tbl[i].name, tbl[i].exp_pc, tbl[i].exp_ld, tbl[i].exp_run,
                    tbl[i].exp_done, tbl[i].exp_st);
        end
        idle_inputs();
    endtask

    // ---------------- test ----------------
    initial begin
        //                    name        st saddr   br cd idx cmp hl rs  exp_pc  ld run dn state
        vecs_a.push_back(mk("start040",   1, 10'h040, 0, 0, 0, 0, 0, 0, 10'h040, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("plain1",     0, 10'h000, 0, 0, 0, 0, 0, 0, 10'h041, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("plain2",     0, 10'h000, 0, 0, 0, 0, 0, 0, 10'h042, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("plain3",     0, 10'h000, 0, 0, 0, 0, 0, 0, 10'h043, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("cbr_nt",     0, 10'h000, 1, 1, 3, 0, 0, 0, 10'h044, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("cbr_t",      0, 10'h000, 1, 1, 3, 1, 0, 0, 10'h120, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("plain4",     0, 10'h000, 0, 0, 0, 0, 0, 0, 10'h121, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("ubr",        0, 10'h000, 1, 0, 3, 0, 0, 0, 10'h120, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("plain5",     0, 10'h000, 0, 0, 0, 0, 0, 0, 10'h121, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("start_run",  1, 10'h300, 0, 0, 0, 0, 0, 0, 10'h122, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("br_idx0",    0, 10'h000, 1, 0, 0, 0, 0, 0, 10'h123, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("br_idx5",    0, 10'h000, 1, 0, 5, 0, 0, 0, 10'h00F, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("plain6",     0, 10'h000, 0, 0, 0, 0, 0, 0, 10'h010, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("regset",     0, 10'h000, 0, 0, 0, 0, 0, 1, 10'h011, 1, 1, 0, ST_LOADREG));
        vecs_a.push_back(mk("payload_br", 0, 10'h000, 1, 0, 3, 0, 0, 0, 10'h012, 1, 1, 0, ST_LOADREG));
        vecs_a.push_back(mk("payload_hl", 0, 10'h000, 0, 0, 0, 0, 1, 0, 10'h013, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("br_idx6",    0, 10'h000, 1, 0, 6, 0, 0, 0, 10'h054, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("plain7",     0, 10'h000, 0, 0, 0, 0, 0, 0, 10'h055, 0, 1, 0, ST_RUN));
        vecs_a.push_back(mk("halt_br",    0, 10'h000, 1, 0, 3, 0, 1, 0, 10'h055, 0, 0, 1, ST_HALTED));

        vecs_b.push_back(mk("restart0",   1, 10'h000, 0, 0, 0, 0, 0, 0, 10'h000, 0, 1, 0, ST_RUN));
        vecs_b.push_back(mk("br_idx7",    0, 10'h000, 1, 0, 7, 0, 0, 0, 10'h3FF, 0, 1, 0, ST_RUN));
        vecs_b.push_back(mk("wrap",       0, 10'h000, 0, 0, 0, 0, 0, 0, 10'h000, 0, 1, 0, ST_RUN));
        vecs_b.push_back(mk("br_idx8",    0, 10'h000, 1, 0, 8, 0, 0, 0, 10'h1F3, 0, 1, 0, ST_RUN));

        idle_inputs();

        // Reset asserted before any clock edge.
        ResetN = 1'b0;
        #2;
        chk_all("por", 10'h000, 0, 0, 0, ST_IDLE);
        step();
        ResetN = 1'b1;
        step();
        chk_all("idle_no_start", 10'h000, 0, 0, 0, ST_IDLE);

        run_table(vecs_a);

        // HALTED holds PC and Done for 10 cycles whatever the decoder shows.
        for (int i = 0; i < 10; i++) begin
            BranchEn = (i % 2 == 0); BranchIdx = 4'd3; RegSet = (i % 3 == 0);
            Halt = (i % 4 == 1);
            step();
            chk_all($sformatf("hold%0d", i), 10'h055, 0, 0, 1, ST_HALTED);
        end
        idle_inputs();

        run_table(vecs_b);

        // Asynchronous reset mid-RUN at PC 0x1F3: visible before the next edge.
        ResetN = 1'b0;
        #2;
        chk_all("rst_run", 10'h000, 0, 0, 0, ST_IDLE);
        #1;
        ResetN = 1'b1;
        step();
        chk_all("rst_run_rel", 10'h000, 0, 0, 0, ST_IDLE);

        // Asynchronous reset in the middle of a register load.
        Start = 1'b1; StartAddr = 10'h010;
        step();
        idle_inputs();
        RegSet = 1'b1;
        step();
        idle_inputs();
        chk_all("ld_pre_rst", 10'h011, 1, 1, 0, ST_LOADREG);
        ResetN = 1'b0;
        #2;
        chk_all("rst_ld", 10'h000, 0, 0, 0, ST_IDLE);
        #1;
        ResetN = 1'b1;
        step();
        chk_all("rst_ld_rel", 10'h000, 0, 0, 0, ST_IDLE);
        step();
        chk_all("rst_ld_rel2", 10'h000, 0, 0, 0, ST_IDLE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #100000;
        n_errors++;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fetch_unit
